run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl.sv | 126 ++++++++++++
 tb/tb_run_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: sequences reset, run, drain and done phases for a controlled block.
// Define RUN_CTRL_TIMEOUT_EN to enable the RUN-phase watchdog (TOUT state).
module run_ctrl #(
    parameter int unsigned RST_CYCLES   = 4,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 100
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        start,
    input  logic        finish_req,
    input  logic        clear,
    output logic        dut_reset_l,
    output logic        running,
    output logic        done,
    output logic        timeout,
    output logic [31:0] cycle_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_TOUT  = 3'd5
    } state_t;

    localparam logic [31:0] HOLD_INIT  = (RST_CYCLES == 0) ? 32'd1 : 32'(RST_CYCLES);
    localparam logic [31:0] DRAIN_INIT = 32'(DRAIN_CYCLES);
    localparam logic [31:0] WD_LAST    = 32'(MAX_CYCLES - 1);

`ifdef RUN_CTRL_TIMEOUT_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    state_t      cur, nxt;
    logic [31:0] hold_cnt, hold_nxt;
    logic [31:0] drain_cnt, drain_nxt;
    logic [31:0] cnt, cnt_nxt;

    always_comb begin
        nxt       = cur;
        hold_nxt  = hold_cnt;
        drain_nxt = drain_cnt;
        cnt_nxt   = cnt;
        if (clear) begin
            nxt       = S_IDLE;
            hold_nxt  = '0;
            drain_nxt = '0;
            cnt_nxt   = '0;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (start) begin
                        nxt      = S_RST;
                        hold_nxt = HOLD_INIT;
                        cnt_nxt  = '0;
                    end
                end
                S_RST: begin
                    if (hold_cnt <= 32'd1) begin
                        nxt      = S_RUN;
                        hold_nxt = '0;
                    end else begin
                        hold_nxt = hold_cnt - 32'd1;
                    end
                end
                S_RUN: begin
                    // finish_req is checked first so it wins a tie with the watchdog
                    if (finish_req) begin
                        if (DRAIN_CYCLES == 0) begin
                            nxt = S_DONE;
                        end else begin
                            nxt       = S_DRAIN;
                            drain_nxt = DRAIN_INIT;
                        end
                    end else if (WD_EN && (cnt == WD_LAST)) begin
                        nxt = S_TOUT;
                    end else if (cnt != '1) begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt <= 32'd1) begin
                        nxt       = S_DONE;
                        drain_nxt = '0;
                    end else begin
                        drain_nxt = drain_cnt - 32'd1;
                    end
                end
                S_DONE, S_TOUT: ;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cur         <= S_IDLE;
            hold_cnt    <= '0;
            drain_cnt   <= '0;
            cnt         <= '0;
            dut_reset_l <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            cur         <= nxt;
            hold_cnt    <= hold_nxt;
            drain_cnt   <= drain_nxt;
            cnt         <= cnt_nxt;
            dut_reset_l <= (nxt == S_RUN) || (nxt == S_DRAIN) || (nxt == S_DONE);
            running     <= (nxt == S_RUN);
            done        <= (nxt == S_DONE);
            timeout     <= WD_EN && (nxt == S_TOUT);
        end
    end

    assign cycle_count = cnt;
    assign state       = cur;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: two instances (default and zero-length phases)
// share stimulus; a phase/age reference model predicts every cycle's outputs.
module tb_run_ctrl;

    localparam int unsigned A_RST = 4, A_DRAIN = 2;
    localparam int unsigned B_RST = 0, B_DRAIN = 0;
    localparam int unsigned MAXC  = 10;
`ifdef RUN_CTRL_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int unsigned P_IDLE = 0, P_RST = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4, P_TOUT = 5;

    typedef struct packed {
        logic        drl;
        logic        run;
        logic        done;
        logic        tout;
        logic [31:0] cnt;
        logic [2:0]  st;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    logic clk = 1'b0;
    logic reset_l = 1'b0, start = 1'b0, finish_req = 1'b0, clear = 1'b0;

    logic        drl_a, run_a, done_a, to_a, drl_b, run_b, done_b, to_b;
    logic [31:0] cc_a, cc_b;
    logic [2:0]  st_a, st_b;
    obs_t        act_a, act_b;

    assign act_a = {drl_a, run_a, done_a, to_a, cc_a, st_a};
    assign act_b = {drl_b, run_b, done_b, to_b, cc_b, st_b};

    always #5 clk = ~clk;

    run_ctrl #(.RST_CYCLES(A_RST), .DRAIN_CYCLES(A_DRAIN), .MAX_CYCLES(MAXC)) dut_a (
        .clk(clk), .reset_l(reset_l), .start(start), .finish_req(finish_req), .clear(clear),
        .dut_reset_l(drl_a), .running(run_a), .done(done_a), .timeout(to_a),
        .cycle_count(cc_a), .state(st_a)
    );

    run_ctrl #(.RST_CYCLES(B_RST), .DRAIN_CYCLES(B_DRAIN), .MAX_CYCLES(MAXC)) dut_b (
        .clk(clk), .reset_l(reset_l), .start(start), .finish_req(finish_req), .clear(clear),
        .dut_reset_l(drl_b), .running(run_b), .done(done_b), .timeout(to_b),
        .cycle_count(cc_b), .state(st_b)
    );

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Reference model: current phase, clocks spent in it, and RUN clocks counted.
    int unsigned m_phase[2];
    int unsigned m_age[2];
    logic [31:0] m_runs[2];

    function automatic int unsigned rst_len(input int i);
        int unsigned r;
        r = (i == 0) ? A_RST : B_RST;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned drain_len(input int i);
        return (i == 0) ? A_DRAIN : B_DRAIN;
    endfunction

    function automatic void model_reset(input int i);
        m_phase[i] = P_IDLE;
        m_age[i]   = 0;
        m_runs[i]  = '0;
    endfunction

    function automatic void model_step(input int i, input logic s, input logic f, input logic c);
        if (c) begin
            model_reset(i);
            return;
        end
        m_age[i]++;
        case (m_phase[i])
            P_IDLE: if (s) begin
                m_phase[i] = P_RST;
                m_age[i]   = 0;
                m_runs[i]  = '0;
            end
            P_RST: if (m_age[i] >= rst_len(i)) begin
                m_phase[i] = P_RUN;
                m_age[i]   = 0;
            end
            P_RUN: begin
                if (f) begin
                    m_phase[i] = (drain_len(i) == 0) ? P_DONE : P_DRAIN;
                    m_age[i]   = 0;
                end else if (WD && m_runs[i] == 32'(MAXC - 1)) begin
                    m_phase[i] = P_TOUT;
                    m_age[i]   = 0;
                end else if (m_runs[i] != 32'hFFFF_FFFF) begin
                    m_runs[i] = m_runs[i] + 32'd1;
                end
            end
            P_DRAIN: if (m_age[i] >= drain_len(i)) begin
                m_phase[i] = P_DONE;
                m_age[i]   = 0;
            end
            default: ;
        endcase
    endfunction

    function automatic obs_t model_obs(input int i);
        obs_t o;
        o.drl  = (m_phase[i] == P_RUN) || (m_phase[i] == P_DRAIN) || (m_phase[i] == P_DONE);
        o.run  = (m_phase[i] == P_RUN);
        o.done = (m_phase[i] == P_DONE);
        o.tout = (m_phase[i] == P_TOUT);
        o.cnt  = m_runs[i];
        o.st   = 3'(m_phase[i]);
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got drl=%b run=%b done=%b tout=%b cnt=%0d st=%0d required drl=%b run=%b done=%b tout=%b cnt=%0d st=%0d",
                     name, $time, got.drl, got.run, got.done, got.tout, got.cnt, got.st,
                     exp.drl, exp.run, exp.done, exp.tout, exp.cnt, exp.st);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("out_a", act_a, e.a);
                check("out_b", act_b, e.b);
            end
        end
    end

    // One cycle of stimulus, issued just after a rising edge.
    task automatic cyc(input logic r, input logic s, input logic f, input logic c);
        exp_t e;
        reset_l    = r;
        start      = s;
        finish_req = f;
        clear      = c;
        if (!r) begin
            model_reset(0);
            model_reset(1);
        end
        e.a = model_obs(0);
        e.b = model_obs(1);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            model_step(0, s, f, c);
            model_step(1, s, f, c);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until(input logic [31:0] target, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (!(m_phase[0] == P_RUN && m_runs[0] == target) && n < limit) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        @(posedge clk);
        #1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Normal run, finish at count 4, start ignored in DONE, then clear.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        run_until(32'd4, 20);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Start ignored in RUN, async abort at count 5, fresh run with tie at count 9.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        run_until(32'd2, 20);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        run_until(32'd5, 20);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        run_until(32'd9, 30);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Long run without finish (watchdog if enabled), then clear.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(20);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Clear in the middle of the reset hold.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);

        repeat (1500) begin
            cyc(($urandom_range(99) != 0), ($urandom_range(3) == 0),
                ($urandom_range(7) == 0), ($urandom_range(39) == 0));
        end
        idle(2);

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
